// File: rtl/barret_reduce_pipe.sv
// barret_reduce_pipe
// Three-stage pipelined Barrett reduction: dout_r = din_a mod Q.
// An opaque tag travels with each operand so results can be matched to
// their requests. A single stall signal freezes the whole pipe when the
// output holds a result that the consumer has not yet taken.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : din_a/din_tag carry an operand
//   in_ready   : block accepts an operand this cycle
//   din_a      : unsigned operand, W_IN bits
//   din_tag    : tag returned alongside the result
//   out_valid  : dout_r/dout_tag carry a result
//   out_ready  : consumer takes the result this cycle
//   dout_r     : din_a mod Q, W_OUT bits
//   dout_tag   : tag that accompanied the operand
//   busy       : some pipeline stage holds a valid entry
module barret_reduce_pipe #(
    parameter int unsigned Q     = 499,
    parameter int unsigned W_IN  = 17,
    parameter int unsigned W_OUT = 9,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  din_a,
    input  logic [TAG_W-1:0] din_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] dout_r,
    output logic [TAG_W-1:0] dout_tag,
    output logic             busy
);

    // K equals the operand width, so MU = floor(2^K / Q) always fits in
    // W_IN bits (Q >= 3) and the quotient estimate p >> K never exceeds
    // the true quotient.
    localparam int unsigned     K     = W_IN;
    localparam logic [W_IN:0]   Q_EXT = (W_IN+1)'(Q);
    localparam logic [W_IN:0]   POW_K = (W_IN+1)'(1) << K;
    localparam logic [W_IN-1:0] MU    = W_IN'(POW_K / Q_EXT);

    // Stage registers
    logic             s1_valid;
    logic [W_IN-1:0]  s1_x;
    logic [W_IN-1:0]  s1_qe;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [W_IN:0]    s2_r0;
    logic [TAG_W-1:0] s2_tag;

    logic             s3_valid;
    logic [W_OUT-1:0] s3_r;
    logic [TAG_W-1:0] s3_tag;

    // Combinational datapath between stages
    logic [2*W_IN-1:0] p_full;
    logic [W_IN-1:0]   qe_next;
    logic [W_IN:0]     qe_times_q;
    logic [W_IN:0]     r0_next;
    logic [W_IN:0]     r_fix1;
    logic [W_IN:0]     r_fix2;
    logic              advance;

    // The pipe moves whenever the output slot is empty or being drained.
    // in_ready is forced low during reset and never looks at in_valid.
    assign advance  = !s3_valid || out_ready;
    assign in_ready = advance && rst_n;

    assign out_valid = s3_valid;
    assign dout_r    = s3_r;
    assign dout_tag  = s3_tag;
    assign busy      = s1_valid || s2_valid || s3_valid;

    // Stage 1 arithmetic: full product x*MU, then keep only the quotient
    // estimate (p >> K); the low K bits carry no further information.
    always_comb begin
        p_full  = (2*W_IN)'(din_a) * (2*W_IN)'(MU);
        qe_next = W_IN'(p_full >> K);
    end

    // Stage 2 arithmetic: remainder estimate. qe*Q never exceeds x, so
    // the subtraction cannot wrap at W_IN+1 bits.
    always_comb begin
        qe_times_q = {1'b0, s1_qe} * Q_EXT;
        r0_next    = {1'b0, s1_x} - qe_times_q;
    end

    // Stage 3 arithmetic: up to two conditional subtractions of Q bring
    // the estimate into [0, Q).
    always_comb begin
        r_fix1 = (s2_r0 >= Q_EXT) ? (s2_r0 - Q_EXT) : s2_r0;
        r_fix2 = (r_fix1 >= Q_EXT) ? (r_fix1 - Q_EXT) : r_fix1;
    end

    // Pipeline registers: every stage shifts together when advance is
    // high; an empty upstream slot shifts in as a bubble. When advance is
    // low every stage holds, so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_qe    <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_r0    <= '0;
            s2_tag   <= '0;
            s3_valid <= 1'b0;
            s3_r     <= '0;
            s3_tag   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_x     <= din_a;
            s1_qe    <= qe_next;
            s1_tag   <= din_tag;
            s2_valid <= s1_valid;
            s2_r0    <= r0_next;
            s2_tag   <= s1_tag;
            s3_valid <= s2_valid;
            s3_r     <= W_OUT'(r_fix2);
            s3_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// tb_barret_reduce_pipe
// Directed bench for barret_reduce_pipe with the default Q=499 build:
// reset behaviour, exact latency, boundary operands, backpressure hold,
// a strided sweep and a random-handshake stream against a modulo model,
// and reset with operands in flight.
module tb_barret_reduce_pipe;

    localparam int unsigned Q     = 499;
    localparam int unsigned W_IN  = 17;
    localparam int unsigned W_OUT = 9;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W_OUT-1:0] r;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  din_a;
    logic [TAG_W-1:0] din_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] dout_r;
    logic [TAG_W-1:0] dout_tag;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    barret_reduce_pipe #(
        .Q     (Q),
        .W_IN  (W_IN),
        .W_OUT (W_OUT),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .din_tag   (din_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_r    (dout_r),
        .dout_tag  (dout_tag),
        .busy      (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT stops handshaking entirely
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [W_IN-1:0] a,
                                 input logic [TAG_W-1:0] t, input logic rdy);
        in_valid  = v;
        din_a     = a;
        din_tag   = t;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    // One operand into an empty pipe; result must appear exactly three
    // cycles after the accepting cycle and not one cycle earlier.
    task automatic runSingle(input logic [W_IN-1:0] a, input logic [TAG_W-1:0] t,
                             input logic [W_OUT-1:0] expected_r);
        applyStimulus(1'b1, a, t, 1'b1);
        checkOutput("single_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("single_early_valid", out_valid, 0);
        tick();
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_r", dout_r, expected_r);
        checkOutput("single_tag", dout_tag, t);
        tick();
    endtask

    // Streams n operands through a scoreboard. randomMode toggles in_valid
    // and out_ready at random with random operands; otherwise a strided
    // sweep of the operand range with no stalls.
    task automatic runStream(input int n, input bit randomMode);
        logic [W_IN-1:0] ops[$];
        exp_t            expq[$];
        exp_t            front;
        int              sent;
        int              got;
        int              cycles;
        sent   = 0;
        got    = 0;
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            if (randomMode)
                ops.push_back(W_IN'($urandom_range(0, 131071)));
            else
                ops.push_back(W_IN'((i * 37) % 131072));
        end
        while ((got < n) && (cycles < 4 * n + 100)) begin
            out_ready = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < n) begin
                in_valid = randomMode ? ($urandom_range(0, 3) != 0) : 1'b1;
                din_a    = ops[sent];
                din_tag  = TAG_W'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                assert (expq.size() != 0)
                else begin
                    failures++;
                    $error("[TB] FAIL stream_spurious observed=result expected=none");
                end
                if (expq.size() != 0) begin
                    front = expq.pop_front();
                    checkOutput("stream_r", dout_r, front.r);
                    checkOutput("stream_tag", dout_tag, front.tag);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back('{tag: TAG_W'(sent), r: W_OUT'(din_a % W_IN'(Q))});
                sent++;
            end
            tick();
            cycles++;
        end
        checkOutput("stream_count", got, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("stream_idle_busy", busy, 0);
    endtask

    // Directed sequence
    initial begin
        int exp_r[5];
        exp_r = '{0, 498, 0, 0, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din_a     = '0;
        din_tag   = '0;
        out_ready = 1'b1;
        #12;

        // Reset state
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_dout_r", dout_r, 0);
        checkOutput("rst_dout_tag", dout_tag, 0);

        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);
        tick();

        // Back-to-back operands 0, 498, 499, 998, 1000 with tags 0..4
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: applyStimulus(1'b1, 17'd0,    4'd0, 1'b1);
                1: applyStimulus(1'b1, 17'd498,  4'd1, 1'b1);
                2: applyStimulus(1'b1, 17'd499,  4'd2, 1'b1);
                3: applyStimulus(1'b1, 17'd998,  4'd3, 1'b1);
                4: applyStimulus(1'b1, 17'd1000, 4'd4, 1'b1);
                default: applyStimulus(1'b0, 17'd0, 4'd0, 1'b1);
            endcase
            tick();
            if (k >= 2 && k <= 6) begin
                checkOutput("burst_valid", out_valid, 1);
                checkOutput("burst_r", dout_r, exp_r[k-2]);
                checkOutput("burst_tag", dout_tag, k - 2);
            end else begin
                checkOutput("burst_idle", out_valid, 0);
            end
        end

        // Boundary operands
        runSingle(17'd131071, 4'd5, 9'd333);
        runSingle(17'd130738, 4'd6, 9'd0);
        runSingle(17'd130737, 4'd7, 9'd498);
        runSingle(17'd1497,   4'd8, 9'd0);

        // Backpressure: consumer stalls from the second cycle
        applyStimulus(1'b1, 17'd1000, 4'd9, 1'b1);
        tick();
        applyStimulus(1'b1, 17'd131071, 4'd10, 1'b0);
        checkOutput("bp_ready_b", in_ready, 1);
        tick();
        applyStimulus(1'b1, 17'd998, 4'd11, 1'b0);
        checkOutput("bp_ready_c", in_ready, 1);
        tick();
        applyStimulus(1'b1, 17'd500, 4'd12, 1'b0);
        checkOutput("bp_stall_ready", in_ready, 0);
        checkOutput("bp_stall_valid", out_valid, 1);
        checkOutput("bp_stall_r", dout_r, 2);
        checkOutput("bp_stall_tag", dout_tag, 9);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("bp_hold_ready", in_ready, 0);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_r", dout_r, 2);
            checkOutput("bp_hold_tag", dout_tag, 9);
        end
        applyStimulus(1'b1, 17'd500, 4'd12, 1'b1);
        checkOutput("bp_release_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 17'd0, 4'd0, 1'b1);
        checkOutput("bp_b_r", dout_r, 333);
        checkOutput("bp_b_tag", dout_tag, 10);
        tick();
        checkOutput("bp_c_r", dout_r, 0);
        checkOutput("bp_c_tag", dout_tag, 11);
        tick();
        checkOutput("bp_d_valid", out_valid, 1);
        checkOutput("bp_d_r", dout_r, 1);
        checkOutput("bp_d_tag", dout_tag, 12);
        tick();
        checkOutput("bp_drained_valid", out_valid, 0);
        checkOutput("bp_drained_busy", busy, 0);

        // Strided sweep then random handshakes
        runStream(3543, 1'b0);
        runStream(2000, 1'b1);

        // Reset with three operands in flight
        applyStimulus(1'b1, 17'd10, 4'd1, 1'b1);
        tick();
        applyStimulus(1'b1, 17'd20, 4'd2, 1'b1);
        tick();
        applyStimulus(1'b1, 17'd30, 4'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("flight_valid", out_valid, 1);
        checkOutput("flight_r", dout_r, 10);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
        checkOutput("mid_rst_r", dout_r, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("after_rst_valid", out_valid, 0);
            checkOutput("after_rst_busy", busy, 0);
        end
        runSingle(17'd1504, 4'd13, 9'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
